pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 35 +++
 rtl/pipeline_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants and the pipeline controller state encoding.
package riscv_pkg;

   localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
   localparam logic [6:0]  OPC_STORE  = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
   localparam logic [6:0]  OPC_JAL    = 7'b1101111;
   localparam logic [6:0]  OPC_JALR   = 7'b1100111;
   localparam logic [6:0]  OPC_OP     = 7'b0110011;
   localparam logic [6:0]  OPC_OP32   = 7'b0111011;
   localparam logic [27:0] ECALL_LOW  = 28'h0000073;

   typedef enum logic [1:0] {
      CS_RUN        = 2'd0,
      CS_BR_WAIT    = 2'd1,
      CS_TRAP_DRAIN = 2'd2,
      CS_TRAP_REDIR = 2'd3
   } ctrl_state_e;

   // Opcodes whose bits [24:20] name a source register rather than immediate bits.
   function automatic logic reads_rs2(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_OP32) ||
             (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational decode of load-use hazards, control-transfer and ecall
// instructions sitting in the decode latch.
module hazard_detect
   import riscv_pkg::*;
(
   input  logic        de_v,
   input  logic [31:0] de_ir,
   input  logic        exe_v,
   input  logic [31:0] exe_ir,
   output logic        load_use,
   output logic        is_ctrl,
   output logic        is_ecall
);

   logic [4:0] exe_rd_s;
   logic [6:0] de_opc_s;
   logic       exe_is_load_s;
   logic       rs1_hit_s;
   logic       rs2_hit_s;
   logic       unused_s;

   assign exe_rd_s      = exe_ir[11:7];
   assign de_opc_s      = de_ir[6:0];
   assign exe_is_load_s = exe_v && (exe_ir[6:0] == OPC_LOAD) && (exe_rd_s != 5'd0);
   assign rs1_hit_s     = (exe_rd_s == de_ir[19:15]);
   assign rs2_hit_s     = reads_rs2(de_opc_s) && (exe_rd_s == de_ir[24:20]);

   assign load_use = exe_is_load_s && de_v && (rs1_hit_s || rs2_hit_s);
   assign is_ctrl  = de_v && ((de_opc_s == OPC_BRANCH) || (de_opc_s == OPC_JAL) ||
                              (de_opc_s == OPC_JALR));
   assign is_ecall = de_v && (de_ir[27:0] == ECALL_LOW);

   assign unused_s = ^{de_ir[31:28], exe_ir[31:12]};

endmodule

// File: rtl/pipeline_ctrl.sv
// Front-end pipeline controller: load-use bubbles, branch wait, trap drain and
// redirect sequencing, plus a saturating count of fetch-stall cycles.
module pipeline_ctrl
   import riscv_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 32
)(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             DE_V,
   input  logic [31:0]      DE_IR,
   input  logic             EXE_V,
   input  logic [31:0]      EXE_IR,
   input  logic             V_MEM_STALL,
   input  logic             EXE_BR_RESOLVED,
   input  logic             EXE_BR_TAKEN,
   output logic             LD_FETCH,
   output logic             LD_DECODE,
   output logic             DE_BUBBLE,
   output logic             FE_REDIRECT_BR,
   output logic             FE_REDIRECT_TRAP,
   output logic [1:0]       CTRL_STATE,
   output logic [CNT_W-1:0] STALL_CYCLES
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   ctrl_state_e      state_q, state_d;
   logic [DW-1:0]    drain_q, drain_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic load_use_s, is_ctrl_s, is_ecall_s;
   logic ld_fetch_s, ld_decode_s, de_bubble_s, redir_br_s, redir_trap_s;

   hazard_detect u_hazard (
      .de_v     (DE_V),
      .de_ir    (DE_IR),
      .exe_v    (EXE_V),
      .exe_ir   (EXE_IR),
      .load_use (load_use_s),
      .is_ctrl  (is_ctrl_s),
      .is_ecall (is_ecall_s)
   );

   // Next state, drain counter and stage-enable outputs; reset beats the stall hold.
   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      ld_fetch_s   = 1'b0;
      ld_decode_s  = 1'b0;
      de_bubble_s  = 1'b0;
      redir_br_s   = 1'b0;
      redir_trap_s = 1'b0;
      if (RESET) begin
         de_bubble_s = 1'b1;
         state_d     = CS_RUN;
         drain_d     = '0;
      end else if (V_MEM_STALL) begin
         state_d = state_q;
      end else begin
         case (state_q)
            CS_RUN: begin
               if (load_use_s) begin
                  de_bubble_s = 1'b1;
               end else if (is_ctrl_s) begin
                  state_d = CS_BR_WAIT;
               end else if (is_ecall_s) begin
                  drain_d = DW'(DRAIN_CYCLES);
                  state_d = CS_TRAP_DRAIN;
               end else begin
                  ld_fetch_s  = 1'b1;
                  ld_decode_s = 1'b1;
               end
            end
            CS_BR_WAIT: begin
               de_bubble_s = 1'b1;
               if (EXE_BR_RESOLVED) begin
                  redir_br_s = EXE_BR_TAKEN;
                  ld_fetch_s = 1'b1;
                  state_d    = CS_RUN;
               end else begin
                  state_d = state_q;
               end
            end
            CS_TRAP_DRAIN: begin
               de_bubble_s = 1'b1;
               drain_d     = (drain_q == '0) ? '0 : drain_q - DW'(1);
               if (drain_q <= DW'(1)) begin
                  state_d = CS_TRAP_REDIR;
               end else begin
                  state_d = state_q;
               end
            end
            CS_TRAP_REDIR: begin
               // Decode reloads invalid; the stale successor in decode is never issued.
               redir_trap_s = 1'b1;
               ld_fetch_s   = 1'b1;
               ld_decode_s  = 1'b1;
               de_bubble_s  = 1'b1;
               state_d      = CS_RUN;
            end
            default: begin
               state_d = CS_RUN;
            end
         endcase
      end
   end

   // Saturating count of cycles in which fetch does not advance.
   always_comb begin
      if (RESET) begin
         stall_d = '0;
      end else if (!ld_fetch_s && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   // State registers; reset is folded into the _d logic.
   always_ff @(posedge CLK) begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
   end

   assign LD_FETCH         = ld_fetch_s;
   assign LD_DECODE        = ld_decode_s;
   assign DE_BUBBLE        = de_bubble_s;
   assign FE_REDIRECT_BR   = redir_br_s;
   assign FE_REDIRECT_TRAP = redir_trap_s;
   assign CTRL_STATE       = state_q;
   assign STALL_CYCLES     = stall_q;

endmodule
